// File: rtl/ysyx_040750_axi_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter with independent read and write paths.
// Each path owns the external bus for one whole transaction (address, data,
// response) and hands it to the next requester in round-robin order.
// Optional build macro: AXI_ARB_FIXED_PRIO_EN -- replaces round-robin with
// fixed priority (lowest channel index wins); ports and latency unchanged.
module ysyx_040750_axi_rr_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  // per-channel read address / data
  input  logic [NCH*AW-1:0]     I_ch_araddr,
  input  logic [NCH-1:0]        I_ch_arvalid,
  input  logic [NCH*8-1:0]      I_ch_arlen,
  input  logic [NCH*3-1:0]      I_ch_arsize,
  input  logic [NCH*2-1:0]      I_ch_arburst,
  output logic [NCH-1:0]        O_ch_arready,
  output logic [NCH*DW-1:0]     O_ch_rdata,
  output logic [NCH-1:0]        O_ch_rvalid,
  output logic [NCH-1:0]        O_ch_rlast,
  input  logic [NCH-1:0]        I_ch_rready,
  // per-channel write address / data / response
  input  logic [NCH*AW-1:0]     I_ch_awaddr,
  input  logic [NCH-1:0]        I_ch_awvalid,
  input  logic [NCH*8-1:0]      I_ch_awlen,
  input  logic [NCH*3-1:0]      I_ch_awsize,
  input  logic [NCH*2-1:0]      I_ch_awburst,
  output logic [NCH-1:0]        O_ch_awready,
  input  logic [NCH*DW-1:0]     I_ch_wdata,
  input  logic [NCH*DW/8-1:0]   I_ch_wstrb,
  input  logic [NCH-1:0]        I_ch_wlast,
  input  logic [NCH-1:0]        I_ch_wvalid,
  output logic [NCH-1:0]        O_ch_wready,
  output logic [NCH-1:0]        O_ch_bvalid,
  input  logic [NCH-1:0]        I_ch_bready,
  // single external AXI master port
  output logic [AW-1:0]         O_axi_araddr,
  output logic                  O_axi_arvalid,
  output logic [7:0]            O_axi_arlen,
  output logic [2:0]            O_axi_arsize,
  output logic [1:0]            O_axi_arburst,
  input  logic                  I_axi_arready,
  input  logic [DW-1:0]         I_axi_rdata,
  input  logic                  I_axi_rvalid,
  input  logic                  I_axi_rlast,
  output logic                  O_axi_rready,
  output logic [AW-1:0]         O_axi_awaddr,
  output logic                  O_axi_awvalid,
  output logic [7:0]            O_axi_awlen,
  output logic [2:0]            O_axi_awsize,
  output logic [1:0]            O_axi_awburst,
  input  logic                  I_axi_awready,
  output logic [DW-1:0]         O_axi_wdata,
  output logic [DW/8-1:0]       O_axi_wstrb,
  output logic                  O_axi_wlast,
  output logic                  O_axi_wvalid,
  input  logic                  I_axi_wready,
  input  logic                  I_axi_bvalid,
  output logic                  O_axi_bready,
  // current owners, one-hot, zero when idle
  output logic [NCH-1:0]        O_rd_grant,
  output logic [NCH-1:0]        O_wr_grant
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_RESP} w_state_t;

  r_state_t         r_state;
  w_state_t         w_state;
  logic [PW-1:0]    rd_owner;
  logic [PW-1:0]    wr_owner;
  logic [NCH-1:0]   rd_grant;
  logic [NCH-1:0]   wr_grant;
  logic             aw_done;
  logic             w_done;
  logic [PW-1:0]    rd_start;
  logic [PW-1:0]    wr_start;
  logic [PW-1:0]    rd_pick;
  logic [PW-1:0]    wr_pick;

  // Per-channel fields unpacked so the owner index selects a whole field.
  logic [AW-1:0]    araddr_arr  [NCH];
  logic [7:0]       arlen_arr   [NCH];
  logic [2:0]       arsize_arr  [NCH];
  logic [1:0]       arburst_arr [NCH];
  logic [AW-1:0]    awaddr_arr  [NCH];
  logic [7:0]       awlen_arr   [NCH];
  logic [2:0]       awsize_arr  [NCH];
  logic [1:0]       awburst_arr [NCH];
  logic [DW-1:0]    wdata_arr   [NCH];
  logic [SW-1:0]    wstrb_arr   [NCH];

  // First requester at or after 'start', scanning circularly.
  function automatic logic [PW-1:0] pick(input logic [NCH-1:0] req, input logic [PW-1:0] start);
    logic [2*NCH-1:0] rot;
    logic [PW-1:0]    win;
    logic             found;
    int               sum;
    rot   = {req, req} >> start;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = int'(start) + i;
        if (sum >= NCH) sum = sum - NCH;
        win   = PW'(sum);
      end
    end
    return win;
  endfunction

  assign rd_pick = pick(I_ch_arvalid, rd_start);
  assign wr_pick = pick(I_ch_awvalid, wr_start);

  // Handshake / end-of-transaction events.
  logic ar_hs, aw_hs, w_last_hs, rd_end, wr_end, w_busy;
  assign w_busy    = (w_state == W_BUSY);
  assign ar_hs     = O_axi_arvalid & I_axi_arready;
  assign aw_hs     = O_axi_awvalid & I_axi_awready;
  assign w_last_hs = O_axi_wvalid & I_axi_wready & O_axi_wlast;
  assign rd_end    = (r_state == R_DATA) & I_axi_rvalid & O_axi_rready & I_axi_rlast;
  assign wr_end    = (w_state == W_RESP) & I_axi_bvalid & O_axi_bready;

`ifdef AXI_ARB_FIXED_PRIO_EN
  // Fixed priority: every search starts from channel 0.
  assign rd_start = '0;
  assign wr_start = '0;
`else
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(NCH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin pointers move past the owner when its transaction ends.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (rd_end) rd_ptr <= next_idx(rd_owner);
      if (wr_end) wr_ptr <= next_idx(wr_owner);
    end
  end

  assign rd_start = rd_ptr;
  assign wr_start = wr_ptr;
`endif

  // Read FSM: grant on any arvalid, hold owner through the rlast beat.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state  <= R_IDLE;
      rd_owner <= '0;
      rd_grant <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (|I_ch_arvalid) begin
            rd_owner <= rd_pick;
            rd_grant <= NCH'(1) << rd_pick;
            r_state  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) r_state <= R_DATA;
        end
        R_DATA: begin
          if (rd_end) begin
            r_state  <= R_IDLE;
            rd_grant <= '0;
          end
        end
        default: begin
          r_state  <= R_IDLE;
          rd_grant <= '0;
        end
      endcase
    end
  end

  // Write FSM: AW and W forwarded in any order, then wait for the B response.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      w_state  <= W_IDLE;
      wr_owner <= '0;
      wr_grant <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (|I_ch_awvalid) begin
            wr_owner <= wr_pick;
            wr_grant <= NCH'(1) << wr_pick;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            w_state  <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (aw_hs)     aw_done <= 1'b1;
          if (w_last_hs) w_done  <= 1'b1;
          if ((aw_done | aw_hs) && (w_done | w_last_hs)) w_state <= W_RESP;
        end
        W_RESP: begin
          if (wr_end) begin
            w_state  <= W_IDLE;
            wr_grant <= '0;
          end
        end
        default: begin
          w_state  <= W_IDLE;
          wr_grant <= '0;
        end
      endcase
    end
  end

  // Per-channel field unpacking and owner-gated return signals.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign araddr_arr[gi]  = I_ch_araddr[gi*AW +: AW];
      assign arlen_arr[gi]   = I_ch_arlen[gi*8 +: 8];
      assign arsize_arr[gi]  = I_ch_arsize[gi*3 +: 3];
      assign arburst_arr[gi] = I_ch_arburst[gi*2 +: 2];
      assign awaddr_arr[gi]  = I_ch_awaddr[gi*AW +: AW];
      assign awlen_arr[gi]   = I_ch_awlen[gi*8 +: 8];
      assign awsize_arr[gi]  = I_ch_awsize[gi*3 +: 3];
      assign awburst_arr[gi] = I_ch_awburst[gi*2 +: 2];
      assign wdata_arr[gi]   = I_ch_wdata[gi*DW +: DW];
      assign wstrb_arr[gi]   = I_ch_wstrb[gi*SW +: SW];

      assign O_ch_rdata[gi*DW +: DW] = I_axi_rdata;
      assign O_ch_arready[gi] = rd_grant[gi] & (r_state == R_ADDR) & I_axi_arready;
      assign O_ch_rvalid[gi]  = rd_grant[gi] & (r_state == R_DATA) & I_axi_rvalid;
      assign O_ch_rlast[gi]   = rd_grant[gi] & (r_state == R_DATA) & I_axi_rlast;
      assign O_ch_awready[gi] = wr_grant[gi] & w_busy & ~aw_done & I_axi_awready;
      assign O_ch_wready[gi]  = wr_grant[gi] & w_busy & ~w_done & I_axi_wready;
      assign O_ch_bvalid[gi]  = wr_grant[gi] & (w_state == W_RESP) & I_axi_bvalid;
    end
  endgenerate

  // Bus side: owner's request fields pass straight through.
  assign O_axi_araddr  = araddr_arr[rd_owner];
  assign O_axi_arlen   = arlen_arr[rd_owner];
  assign O_axi_arsize  = arsize_arr[rd_owner];
  assign O_axi_arburst = arburst_arr[rd_owner];
  assign O_axi_arvalid = (r_state == R_ADDR) & (|(I_ch_arvalid & rd_grant));
  assign O_axi_rready  = (r_state == R_DATA) & (|(I_ch_rready & rd_grant));

  assign O_axi_awaddr  = awaddr_arr[wr_owner];
  assign O_axi_awlen   = awlen_arr[wr_owner];
  assign O_axi_awsize  = awsize_arr[wr_owner];
  assign O_axi_awburst = awburst_arr[wr_owner];
  assign O_axi_awvalid = w_busy & ~aw_done & (|(I_ch_awvalid & wr_grant));
  assign O_axi_wdata   = wdata_arr[wr_owner];
  assign O_axi_wstrb   = wstrb_arr[wr_owner];
  assign O_axi_wlast   = I_ch_wlast[wr_owner];
  assign O_axi_wvalid  = w_busy & ~w_done & (|(I_ch_wvalid & wr_grant));
  assign O_axi_bready  = (w_state == W_RESP) & (|(I_ch_bready & wr_grant));

  assign O_rd_grant = rd_grant;
  assign O_wr_grant = wr_grant;

endmodule

// File: tb/tb_ysyx_040750_axi_rr_arbiter.sv
// Bench for ysyx_040750_axi_rr_arbiter (NCH=2): table-driven read sequence,
// directed write / concurrency / reset / fairness sequences, and a random
// read-path run against a transaction-level reference model.
module tb_ysyx_040750_axi_rr_arbiter;
  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NCH*AW-1:0]   ch_araddr, ch_awaddr;
  logic [NCH-1:0]      ch_arvalid, ch_arready, ch_rvalid, ch_rlast, ch_rready;
  logic [NCH*8-1:0]    ch_arlen, ch_awlen;
  logic [NCH*3-1:0]    ch_arsize, ch_awsize;
  logic [NCH*2-1:0]    ch_arburst, ch_awburst;
  logic [NCH*DW-1:0]   ch_rdata, ch_wdata;
  logic [NCH-1:0]      ch_awvalid, ch_awready, ch_wlast, ch_wvalid, ch_wready, ch_bvalid, ch_bready;
  logic [NCH*DW/8-1:0] ch_wstrb;
  logic [AW-1:0]       axi_araddr, axi_awaddr;
  logic                axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
  logic [7:0]          axi_arlen, axi_awlen;
  logic [2:0]          axi_arsize, axi_awsize;
  logic [1:0]          axi_arburst, axi_awburst;
  logic [DW-1:0]       axi_rdata, axi_wdata;
  logic                axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
  logic [DW/8-1:0]     axi_wstrb;
  logic [NCH-1:0]      rd_grant, wr_grant;

  ysyx_040750_axi_rr_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .I_clk(clk), .I_rst_n(rst_n),
    .I_ch_araddr(ch_araddr), .I_ch_arvalid(ch_arvalid), .I_ch_arlen(ch_arlen),
    .I_ch_arsize(ch_arsize), .I_ch_arburst(ch_arburst), .O_ch_arready(ch_arready),
    .O_ch_rdata(ch_rdata), .O_ch_rvalid(ch_rvalid), .O_ch_rlast(ch_rlast), .I_ch_rready(ch_rready),
    .I_ch_awaddr(ch_awaddr), .I_ch_awvalid(ch_awvalid), .I_ch_awlen(ch_awlen),
    .I_ch_awsize(ch_awsize), .I_ch_awburst(ch_awburst), .O_ch_awready(ch_awready),
    .I_ch_wdata(ch_wdata), .I_ch_wstrb(ch_wstrb), .I_ch_wlast(ch_wlast), .I_ch_wvalid(ch_wvalid),
    .O_ch_wready(ch_wready), .O_ch_bvalid(ch_bvalid), .I_ch_bready(ch_bready),
    .O_axi_araddr(axi_araddr), .O_axi_arvalid(axi_arvalid), .O_axi_arlen(axi_arlen),
    .O_axi_arsize(axi_arsize), .O_axi_arburst(axi_arburst), .I_axi_arready(axi_arready),
    .I_axi_rdata(axi_rdata), .I_axi_rvalid(axi_rvalid), .I_axi_rlast(axi_rlast), .O_axi_rready(axi_rready),
    .O_axi_awaddr(axi_awaddr), .O_axi_awvalid(axi_awvalid), .O_axi_awlen(axi_awlen),
    .O_axi_awsize(axi_awsize), .O_axi_awburst(axi_awburst), .I_axi_awready(axi_awready),
    .O_axi_wdata(axi_wdata), .O_axi_wstrb(axi_wstrb), .O_axi_wlast(axi_wlast), .O_axi_wvalid(axi_wvalid),
    .I_axi_wready(axi_wready), .I_axi_bvalid(axi_bvalid), .O_axi_bready(axi_bready),
    .O_rd_grant(rd_grant), .O_wr_grant(wr_grant)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ch_araddr = {32'h0000_2000, 32'h0000_1000};
    ch_awaddr = {32'h8000_0000, 32'h0000_4000};
    ch_arvalid = '0; ch_arlen = '0; ch_arsize = {2{3'd3}}; ch_arburst = {2{2'b01}};
    ch_awvalid = '0; ch_awlen = '0; ch_awsize = {2{3'd3}}; ch_awburst = {2{2'b01}};
    ch_rready = '0; ch_wdata = '0; ch_wstrb = '0; ch_wlast = '0; ch_wvalid = '0; ch_bready = '0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  arv;  logic arr; logic rv; logic rl; logic [1:0] rr;
    logic [1:0]  gnt;  logic avld; logic [31:0] addr;
    logic [1:0]  ardy; logic [1:0] rvld; logic [1:0] rlst; logic rrdy;
  } rvec_t;

  rvec_t      tbl [11];
  logic [1:0] alt_exp [4];
  logic [63:0] rd_word;

  // random-run model state
  int          own, beat, cur_len, ptr, k;
  logic [1:0]  req;
  logic [7:0]  mlen [NCH];
  logic [31:0] maddr [NCH];
  logic [1:0]  eg;

  initial begin
    //           arv   arr  rv   rl   rr     gnt   avld addr          ardy   rvld   rlst   rrdy
    tbl[0]  = '{2'b11,1'b0,1'b0,1'b0,2'b11, 2'b00,1'b0,32'h0,        2'b00,2'b00,2'b00,1'b0};
    tbl[1]  = '{2'b11,1'b0,1'b0,1'b0,2'b11, 2'b01,1'b1,32'h0000_1000,2'b00,2'b00,2'b00,1'b0};
    tbl[2]  = '{2'b11,1'b1,1'b0,1'b0,2'b11, 2'b01,1'b1,32'h0000_1000,2'b01,2'b00,2'b00,1'b0};
    tbl[3]  = '{2'b10,1'b0,1'b1,1'b0,2'b11, 2'b01,1'b0,32'h0,        2'b00,2'b01,2'b00,1'b1};
    tbl[4]  = '{2'b10,1'b0,1'b1,1'b1,2'b01, 2'b01,1'b0,32'h0,        2'b00,2'b01,2'b01,1'b1};
    tbl[5]  = '{2'b10,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b0,32'h0,        2'b00,2'b00,2'b00,1'b0};
    tbl[6]  = '{2'b10,1'b1,1'b0,1'b0,2'b00, 2'b10,1'b1,32'h0000_2000,2'b10,2'b00,2'b00,1'b0};
    tbl[7]  = '{2'b00,1'b0,1'b1,1'b0,2'b00, 2'b10,1'b0,32'h0,        2'b00,2'b10,2'b00,1'b0};
    tbl[8]  = '{2'b00,1'b0,1'b1,1'b1,2'b10, 2'b10,1'b0,32'h0,        2'b00,2'b10,2'b10,1'b1};
    tbl[9]  = '{2'b00,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b0,32'h0,        2'b00,2'b00,2'b00,1'b0};
    tbl[10] = '{2'b00,1'b0,1'b0,1'b0,2'b00, 2'b00,1'b0,32'h0,        2'b00,2'b00,2'b00,1'b0};
`ifdef AXI_ARB_FIXED_PRIO_EN
    alt_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    alt_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    // ---- reset state, with requests present during reset ----
    idle_inputs();
    rst_n = 1'b0;
    ch_arvalid = 2'b11; ch_awvalid = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    chk("rst.rd_grant", 64'(rd_grant), 64'h0);
    chk("rst.wr_grant", 64'(wr_grant), 64'h0);
    chk("rst.axi_valids", 64'({axi_arvalid, axi_awvalid, axi_wvalid}), 64'h0);
    chk("rst.axi_readys", 64'({axi_rready, axi_bready}), 64'h0);
    chk("rst.ch_readys", 64'({ch_arready, ch_awready, ch_wready}), 64'h0);
    ch_arvalid = '0; ch_awvalid = '0;
    rst_n = 1'b1;

    // ---- table-driven read sequence ----
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      ch_arvalid = tbl[i].arv; axi_arready = tbl[i].arr; axi_rvalid = tbl[i].rv;
      axi_rlast = tbl[i].rl; ch_rready = tbl[i].rr;
      #1;
      chk($sformatf("tbl%0d.rd_grant", i), 64'(rd_grant), 64'(tbl[i].gnt));
      chk($sformatf("tbl%0d.axi_arvalid", i), 64'(axi_arvalid), 64'(tbl[i].avld));
      chk($sformatf("tbl%0d.ch_arready", i), 64'(ch_arready), 64'(tbl[i].ardy));
      chk($sformatf("tbl%0d.ch_rvalid", i), 64'(ch_rvalid), 64'(tbl[i].rvld));
      chk($sformatf("tbl%0d.ch_rlast", i), 64'(ch_rlast), 64'(tbl[i].rlst));
      chk($sformatf("tbl%0d.axi_rready", i), 64'(axi_rready), 64'(tbl[i].rrdy));
      if (tbl[i].avld) chk($sformatf("tbl%0d.axi_araddr", i), 64'(axi_araddr), 64'(tbl[i].addr));
    end
    idle_inputs();

    // ---- ch1 write, two beats, W accepted before AW ----
    @(negedge clk);
    ch_awvalid = 2'b10; ch_awlen[15:8] = 8'd1;
    ch_wvalid = 2'b11; ch_wdata[127:64] = 64'hD0D0_0000_0000_00D0; ch_wstrb[15:8] = 8'hFF;
    axi_awready = 1'b0; axi_wready = 1'b1;
    #1;
    chk("wr.idle_grant", 64'(wr_grant), 64'h0);
    chk("wr.idle_wready", 64'(ch_wready), 64'h0);
    @(negedge clk); #1;
    chk("wr.grant", 64'(wr_grant), 64'h2);
    chk("wr.axi_awvalid", 64'(axi_awvalid), 64'h1);
    chk("wr.axi_awaddr", 64'(axi_awaddr), 64'h8000_0000);
    chk("wr.axi_awlen", 64'(axi_awlen), 64'h1);
    chk("wr.beat0_wdata", axi_wdata, 64'hD0D0_0000_0000_00D0);
    chk("wr.beat0_wready", 64'(ch_wready), 64'h2);
    chk("wr.awready_held", 64'(ch_awready), 64'h0);
    @(negedge clk);
    ch_wdata[127:64] = 64'hD1D1_0000_0000_00D1; ch_wlast = 2'b10;
    #1;
    chk("wr.beat1_wdata", axi_wdata, 64'hD1D1_0000_0000_00D1);
    chk("wr.beat1_wlast", 64'(axi_wlast), 64'h1);
    chk("wr.beat1_wstrb", 64'(axi_wstrb), 64'hFF);
    @(negedge clk);
    ch_wvalid = 2'b00; ch_wlast = 2'b00; axi_awready = 1'b1;
    #1;
    chk("wr.w_closed", 64'({axi_wvalid, ch_wready}), 64'h0);
    chk("wr.aw_accept", 64'(ch_awready), 64'h2);
    chk("wr.no_early_b", 64'(ch_bvalid), 64'h0);
    @(negedge clk);
    ch_awvalid = 2'b00; axi_awready = 1'b0; axi_bvalid = 1'b1; ch_bready = 2'b10;
    #1;
    chk("wr.bvalid", 64'(ch_bvalid), 64'h2);
    chk("wr.axi_bready", 64'(axi_bready), 64'h1);
    @(negedge clk);
    axi_bvalid = 1'b0; ch_bready = 2'b00;
    #1;
    chk("wr.grant_released", 64'(wr_grant), 64'h0);
    idle_inputs();

    // ---- ch0 read concurrent with ch1 write ----
    @(negedge clk);
    ch_arvalid = 2'b01; ch_awvalid = 2'b10; ch_wvalid = 2'b10; ch_wlast = 2'b10;
    axi_arready = 1'b1; axi_awready = 1'b1; axi_wready = 1'b1;
    @(negedge clk); #1;
    chk("cc.grants", 64'({rd_grant, wr_grant}), 64'b0110);
    chk("cc.axi_valids", 64'({axi_arvalid, axi_awvalid, axi_wvalid}), 64'b111);
    @(negedge clk);
    ch_arvalid = '0; ch_awvalid = '0; ch_wvalid = '0; ch_wlast = '0;
    axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
    rd_word = {$urandom, $urandom};
    axi_rdata = rd_word; axi_rvalid = 1'b1; axi_rlast = 1'b1; ch_rready = 2'b01;
    axi_bvalid = 1'b1; ch_bready = 2'b10;
    #1;
    chk("cc.ch_rvalid", 64'(ch_rvalid), 64'h1);
    chk("cc.ch_bvalid", 64'(ch_bvalid), 64'h2);
    chk("cc.rdata_ch0", ch_rdata[63:0], rd_word);
    chk("cc.rdata_ch1", ch_rdata[127:64], rd_word);
    chk("cc.grants_held", 64'({rd_grant, wr_grant}), 64'b0110);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("cc.released", 64'({rd_grant, wr_grant}), 64'h0);

    // ---- reset during the data phase of a ch1 read ----
    @(negedge clk);
    ch_arvalid = 2'b10; axi_arready = 1'b1;
    @(negedge clk); #1;
    chk("rr.ch1_grant", 64'(rd_grant), 64'h2);
    @(negedge clk);
    ch_arvalid = '0; axi_arready = 1'b0; ch_rready = 2'b10;
    #1;
    chk("rr.rready_before", 64'(axi_rready), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr.rready_async", 64'(axi_rready), 64'h0);
    chk("rr.grant_async", 64'(rd_grant), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; ch_arvalid = 2'b11; ch_rready = '0;
    #1;
    chk("rr.idle_after", 64'(rd_grant), 64'h0);
    @(negedge clk); #1;
    chk("rr.ch0_first", 64'(rd_grant), 64'h1);

    // ---- both channels requesting continuously ----
    reset_dut();
    ch_arvalid = 2'b11; axi_arready = 1'b1; axi_rvalid = 1'b1; axi_rlast = 1'b1; ch_rready = 2'b11;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); #1;
      chk($sformatf("alt%0d.rd_grant", t), 64'(rd_grant), 64'(alt_exp[t]));
      @(negedge clk);
      @(negedge clk);
    end

    // ---- randomized read traffic against a transaction-level model ----
    reset_dut();
    own = -1; beat = 0; cur_len = 0; ptr = 0; req = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int m = 0; m < NCH; m++) begin
        if (!req[m] && $urandom_range(0, 3) == 0) begin
          req[m]   = 1'b1;
          mlen[m]  = 8'($urandom_range(0, 3));
          maddr[m] = $urandom;
          ch_araddr[m*AW +: AW] = maddr[m];
          ch_arlen[m*8 +: 8]    = mlen[m];
        end
      end
      ch_arvalid  = req;
      ch_rready   = 2'($urandom_range(0, 3));
      axi_arready = 1'($urandom_range(0, 1));
      axi_rvalid  = 1'($urandom_range(0, 1));
      axi_rlast   = (own >= 0) && (beat == cur_len);
      axi_rdata   = {$urandom, $urandom};
      #1;
      eg = (own >= 0) ? 2'(1 << own) : 2'b00;
      chk($sformatf("rnd%0d.rd_grant", c), 64'(rd_grant), 64'(eg));
      if (own < 0) begin
        chk($sformatf("rnd%0d.idle_quiet", c), 64'({axi_arvalid, axi_rready, ch_arready, ch_rvalid}), 64'h0);
      end else if (beat < 0) begin
        // address phase of the current owner
        chk($sformatf("rnd%0d.axi_arvalid", c), 64'(axi_arvalid), 64'(req[own]));
        chk($sformatf("rnd%0d.ch_arready", c), 64'(ch_arready), axi_arready ? 64'(eg) : 64'h0);
        chk($sformatf("rnd%0d.no_rvalid", c), 64'(ch_rvalid), 64'h0);
        if (req[own]) begin
          chk($sformatf("rnd%0d.axi_araddr", c), 64'(axi_araddr), 64'(maddr[own]));
          chk($sformatf("rnd%0d.axi_arlen", c), 64'(axi_arlen), 64'(mlen[own]));
        end
      end else begin
        // data phase of the current owner
        chk($sformatf("rnd%0d.ch_rvalid", c), 64'(ch_rvalid), axi_rvalid ? 64'(eg) : 64'h0);
        chk($sformatf("rnd%0d.axi_rready", c), 64'(axi_rready), 64'(ch_rready[own]));
        chk($sformatf("rnd%0d.no_arvalid", c), 64'({axi_arvalid, ch_arready}), 64'h0);
      end
      // advance the model by what the coming clock edge accepts
      if (own < 0) begin
        for (int i = 0; i < NCH; i++) begin
          k = (ptr + i) % NCH;
          if (own < 0 && req[k]) own = k;
        end
        beat = -1;
      end else if (beat < 0) begin
        if (req[own] && axi_arready) begin
          req[own] = 1'b0;
          cur_len  = int'(mlen[own]);
          beat     = 0;
        end
      end else if (axi_rvalid && ch_rready[own]) begin
        if (beat == cur_len) begin
`ifndef AXI_ARB_FIXED_PRIO_EN
          ptr = (own + 1) % NCH;
`endif
          own = -1;
        end else begin
          beat++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
